// File: rtl/mem_port_arbiter.sv
// Byte-wide external memory bus owner: arbitrates fetch and load/store ports,
// serialises each access into byte cycles and reassembles read data little-endian.
module mem_port_arbiter #(
  parameter logic [1:0] IO_HI     = 2'b11,
  parameter int         FETCH_LEN = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic        io_buffer_full,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [2:0]  d_len,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  localparam logic [2:0] FETCH_N = 3'(FETCH_LEN);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t      state;
  logic        last_grant;
  logic        owner_d;
  logic [31:0] base_addr;
  logic [2:0]  len;
  logic [31:8] wdata_hi;
  logic [2:0]  cnt;
  logic [31:0] rbuf;

  logic        grant_i;
  logic        grant_d;
  logic [2:0]  d_n;
  logic [31:0] rbuf_next;
  logic [7:0]  wbyte;
  logic        io_stall;
  logic        io_stall_new;

  // last_grant: 0 = fetch port, 1 = data port; a tie goes to the other side
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!flush) begin
      if (i_req && d_req) begin
        if (last_grant) grant_i = 1'b1;
        else            grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end
    end
  end

  always_comb begin
    case (d_len)
      3'd1:    d_n = 3'd1;
      3'd2:    d_n = 3'd2;
      default: d_n = 3'd4;
    endcase
  end

  // In cycle cnt the bus returns the byte addressed in cycle cnt-1
  always_comb begin
    rbuf_next = rbuf;
    case (cnt)
      3'd2:    rbuf_next[7:0]   = mem_din;
      3'd3:    rbuf_next[15:8]  = mem_din;
      3'd4:    rbuf_next[23:16] = mem_din;
      3'd5:    rbuf_next[31:24] = mem_din;
      default: ;
    endcase
  end

  always_comb begin
    wbyte = wdata_hi[31:24];
    case (cnt)
      3'd1:    wbyte = wdata_hi[15:8];
      3'd2:    wbyte = wdata_hi[23:16];
      default: ;
    endcase
  end

  assign io_stall     = (base_addr[17:16] == IO_HI) && io_buffer_full;
  assign io_stall_new = (d_addr[17:16] == IO_HI) && io_buffer_full;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      owner_d    <= 1'b0;
      base_addr  <= '0;
      len        <= '0;
      wdata_hi   <= '0;
      cnt        <= '0;
      rbuf       <= '0;
      i_done     <= 1'b0;
      i_rdata    <= '0;
      d_done     <= 1'b0;
      d_rdata    <= '0;
      mem_dout   <= '0;
      mem_a      <= '0;
      mem_wr     <= 1'b0;
    end else if (rdy_in) begin
      case (state)
        S_IDLE: begin
          if (grant_i || grant_d) begin
            owner_d    <= grant_d;
            last_grant <= grant_d;
            base_addr  <= grant_d ? d_addr : i_addr;
            len        <= grant_d ? d_n : FETCH_N;
            wdata_hi   <= d_wdata[31:8];
            rbuf       <= '0;
            cnt        <= 3'd1;
            mem_a      <= grant_d ? d_addr : i_addr;
            if (grant_d && d_wr) begin
              state    <= S_WR;
              mem_dout <= d_wdata[7:0];
              mem_wr   <= !io_stall_new;
            end else begin
              state <= S_RD;
            end
          end
        end

        S_RD: begin
          if (flush) begin
            state <= S_IDLE;
            mem_a <= '0;
          end else begin
            rbuf <= rbuf_next;
            if (cnt == len + 3'd1) begin
              state <= S_DONE;
              mem_a <= '0;
              if (owner_d) begin
                d_done  <= 1'b1;
                d_rdata <= rbuf_next;
              end else begin
                i_done  <= 1'b1;
                i_rdata <= rbuf_next;
              end
            end else begin
              cnt   <= cnt + 3'd1;
              mem_a <= (cnt < len) ? base_addr + 32'(cnt) : '0;
            end
          end
        end

        // A cycle with mem_wr=0 is an I/O stall: the byte is held, not advanced
        S_WR: begin
          if (mem_wr) begin
            if (cnt == len) begin
              state    <= S_DONE;
              d_done   <= 1'b1;
              mem_a    <= '0;
              mem_dout <= '0;
              mem_wr   <= 1'b0;
            end else begin
              cnt      <= cnt + 3'd1;
              mem_a    <= base_addr + 32'(cnt);
              mem_dout <= wbyte;
              mem_wr   <= !io_stall;
            end
          end else begin
            mem_wr <= !io_stall;
          end
        end

        S_DONE: begin
          i_done <= 1'b0;
          d_done <= 1'b0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte memory model and a scoreboard
// of expected done pulses (port and read data).
module tb_mem_port_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush;
  logic        io_buffer_full;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [2:0]  d_len;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_d;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  bit [7:0] mem [65536];

  mem_port_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .io_buffer_full(io_buffer_full),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_len(d_len), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] init_byte(logic [15:0] a);
    case (a)
      16'h1000: return 8'h13;
      16'h1001: return 8'h05;
      16'h1002: return 8'h00;
      16'h1003: return 8'h00;
      default:  return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] exp_read(logic [31:0] a, int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = init_byte(16'(a + 32'(i)));
    return r;
  endfunction

  // Memory answers one cycle after the address and freezes with rdy_in
  always @(posedge clk_in) begin
    if (rst_in) begin
      for (int k = 0; k < 65536; k++) mem[k] <= init_byte(16'(k));
    end else if (rdy_in) begin
      mem_din <= mem[mem_a[15:0]];
      if (mem_wr) mem[mem_a[15:0]] <= mem_dout;
    end
  end

  task automatic check_output(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every done pulse must match the oldest outstanding expectation
  always @(negedge clk_in) begin
    if (!rst_in && rdy_in && (i_done || d_done)) begin
      check_output("sb_done_expected", {31'b0, sb.size() > 0}, 32'd1);
      check_output("sb_both_done", {31'b0, i_done & d_done}, 32'd0);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check_output("sb_port", {31'b0, d_done}, {31'b0, e.is_d});
        if (e.chk_data) check_output("sb_rdata", e.is_d ? d_rdata : i_rdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic apply_stimulus_reset();
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0;
    d_addr = '0; d_len = 3'd4; d_wdata = '0;
    sb.delete();
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  task automatic issue_i(logic [31:0] a, logic [31:0] exp);
    exp_t e;
    e.is_d = 1'b0; e.chk_data = 1'b1; e.data = exp;
    sb.push_back(e);
    i_addr = a;
    i_req  = 1'b1;
  endtask

  task automatic issue_d(logic wr, logic [31:0] a, logic [2:0] n,
                         logic [31:0] wd, logic [31:0] exp);
    exp_t e;
    e.is_d = 1'b1; e.chk_data = !wr; e.data = exp;
    sb.push_back(e);
    d_wr = wr; d_addr = a; d_len = n; d_wdata = wd;
    d_req = 1'b1;
  endtask

  task automatic wait_done(string tag, logic want_d, int budget);
    int n = 0;
    while (!(want_d ? d_done : i_done) && n < budget) begin
      tick();
      n++;
    end
    check_output(tag, {31'b0, want_d ? d_done : i_done}, 32'd1);
  endtask

  initial begin
    // Reset held while requests toggle: bus and done lines stay quiet
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    i_req = 1'b0; i_addr = 32'h1000; d_req = 1'b0; d_wr = 1'b1;
    d_addr = 32'h20; d_len = 3'd4; d_wdata = 32'h12345678;
    for (int k = 0; k < 4; k++) begin
      i_req = k[0];
      d_req = !k[0];
      tick();
      check_output("rst_mem_a", mem_a, 32'd0);
      check_output("rst_ctl", {21'b0, mem_wr, i_done, d_done, mem_dout}, 32'd0);
      check_output("rst_rdata", i_rdata | d_rdata, 32'd0);
    end
    apply_stimulus_reset();

    // Instruction fetch of 13 05 00 00 at 0x1000
    issue_i(32'h1000, 32'h0000_0513);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check_output("fetch_addr", mem_a, 32'h1000 + 32'(c - 1));
      check_output("fetch_wr", {31'b0, mem_wr}, 32'd0);
    end
    tick();
    check_output("fetch_early_done", {31'b0, i_done}, 32'd0);
    tick();
    check_output("fetch_done_c6", {31'b0, i_done}, 32'd1);
    check_output("fetch_rdata", i_rdata, 32'h0000_0513);
    i_req = 1'b0;
    tick();

    // Two-byte store, then read it back
    issue_d(1'b1, 32'h20, 3'd2, 32'h0000_BEEF, 32'h0);
    tick();
    check_output("wr_c1_addr", mem_a, 32'h20);
    check_output("wr_c1_data", {23'b0, mem_wr, mem_dout}, {23'b0, 1'b1, 8'hEF});
    tick();
    check_output("wr_c2_addr", mem_a, 32'h21);
    check_output("wr_c2_data", {23'b0, mem_wr, mem_dout}, {23'b0, 1'b1, 8'hBE});
    tick();
    check_output("wr_done_c3", {31'b0, d_done}, 32'd1);
    check_output("wr_done_bus", {23'b0, mem_wr, mem_dout}, 32'd0);
    d_req = 1'b0;
    tick();
    issue_d(1'b0, 32'h20, 3'd2, 32'h0, 32'h0000_BEEF);
    wait_done("readback_done", 1'b1, 10);
    d_req = 1'b0;
    tick();

    // Simultaneous requests alternate starting with the fetch port
    apply_stimulus_reset();
    for (int r = 0; r < 2; r++) begin
      issue_i(32'h1000, 32'h0000_0513);
      issue_d(1'b0, 32'h200, 3'd4, 32'h0, exp_read(32'h200, 4));
      wait_done("tie_i_first", 1'b0, 12);
      i_req = 1'b0;
      wait_done("tie_d_second", 1'b1, 12);
      d_req = 1'b0;
      tick();
    end

    // Flush aborts a data read; flush also blocks a grant in IDLE
    d_wr = 1'b0; d_addr = 32'h100; d_len = 3'd4; d_req = 1'b1;
    tick();
    check_output("flush_c1_addr", mem_a, 32'h100);
    tick();
    check_output("flush_c2_addr", mem_a, 32'h101);
    flush = 1'b1;
    d_req = 1'b0;
    tick();
    check_output("flush_idle_addr", mem_a, 32'd0);
    issue_i(32'h1000, 32'h0000_0513);
    tick();
    check_output("flush_no_grant", mem_a, 32'd0);
    flush = 1'b0;
    tick();
    check_output("post_flush_grant", mem_a, 32'h1000);
    wait_done("post_flush_done", 1'b0, 10);
    i_req = 1'b0;
    tick();

    // I/O write stalls while the uart buffer is full
    io_buffer_full = 1'b1;
    issue_d(1'b1, 32'h0003_0000, 3'd1, 32'h41, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) io_buffer_full = 1'b0;
      check_output("io_stall_wr", {31'b0, mem_wr}, 32'd0);
      check_output("io_stall_addr", mem_a, 32'h0003_0000);
    end
    tick();
    check_output("io_write", {23'b0, mem_wr, mem_dout}, {23'b0, 1'b1, 8'h41});
    tick();
    check_output("io_done", {31'b0, d_done}, 32'd1);
    d_req = 1'b0;
    tick();

    // Length code 3 reads four bytes; address wraps past 0xFFFFFFFF
    apply_stimulus_reset();
    issue_d(1'b0, 32'hFFFF_FFFE, 3'd3, 32'h0, exp_read(32'hFFFF_FFFE, 4));
    for (int c = 1; c <= 4; c++) begin
      tick();
      check_output("wrap_addr", mem_a, 32'hFFFF_FFFE + 32'(c - 1));
    end
    wait_done("wrap_done", 1'b1, 6);
    d_req = 1'b0;
    tick();
    issue_d(1'b0, 32'h1001, 3'd1, 32'h0, 32'h0000_0005);
    wait_done("len1_done", 1'b1, 6);
    d_req = 1'b0;
    tick();

    // rdy_in low freezes a fetch mid-flight
    issue_i(32'h1000, 32'h0000_0513);
    tick();
    tick();
    rdy_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_output("freeze_addr", mem_a, 32'h1001);
      check_output("freeze_done", {31'b0, i_done}, 32'd0);
    end
    rdy_in = 1'b1;
    wait_done("freeze_resume_done", 1'b0, 10);
    i_req = 1'b0;
    tick();

    // Reset in the middle of a fetch clears everything at once
    i_addr = 32'h1000; i_req = 1'b1;
    tick();
    tick();
    rst_in = 1'b1;
    #1;
    check_output("midrst_addr", mem_a, 32'd0);
    check_output("midrst_rdata", i_rdata, 32'd0);
    i_req = 1'b0;
    tick();
    rst_in = 1'b0;
    for (int c = 0; c < 8; c++) tick();

    check_output("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
